// File: rtl/spi_cmd_sched.sv
`default_nettype none
// ============================================================================
//  Module   : spi_cmd_sched
//  Purpose  : Command scheduler in front of an SPI master. Queues host
//             commands, issues them one at a time over a valid/ready
//             handshake, tracks each transfer to completion, collects read
//             data in a response FIFO and flags timeout / unexpected data.
//  Revision : 1.0  initial release
// ============================================================================
module spi_cmd_sched #(
    parameter int CMD_WIDTH  = 12,
    parameter int READ_WIDTH = 8,
    parameter int RW_BIT     = 11,
    parameter int CMD_DEPTH  = 8,
    parameter int RSP_DEPTH  = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CMD_WIDTH-1:0]         host_cmd,
    input  logic                         host_cmd_vld,
    output logic                         host_cmd_rdy,
    output logic [CMD_WIDTH-1:0]         spi_cmd,
    output logic                         spi_cmd_vld,
    input  logic                         spi_cmd_rdy,
    input  logic                         spi_read_vld,
    input  logic [READ_WIDTH-1:0]        spi_read_data,
    output logic [READ_WIDTH-1:0]        rsp_data,
    output logic                         rsp_vld,
    input  logic                         rsp_rdy,
    output logic [$clog2(CMD_DEPTH):0]   cmd_level,
    output logic                         busy,
    output logic                         err_timeout,
    output logic                         err_unexp,
    input  logic                         err_clr
);

    localparam int c_CA = $clog2(CMD_DEPTH);
    localparam int c_RA = $clog2(RSP_DEPTH);
    localparam int c_TW = $clog2(TIMEOUT);

    localparam logic [c_CA:0]   c_CMD_INC = 1;
    localparam logic [c_RA:0]   c_RSP_INC = 1;
    localparam logic [c_TW-1:0] c_TMO_INC = 1;
    localparam logic [c_TW-1:0] c_TMO_MAX = c_TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t                  r_state;
    logic [c_TW-1:0]         r_tmo;
    logic                    r_is_read;
    logic                    r_got_rd;
    logic                    r_err_timeout;
    logic                    r_err_unexp;

    // Command FIFO storage and pointers (extra MSB distinguishes full/empty)
    logic [CMD_WIDTH-1:0]    r_cmd_mem [CMD_DEPTH];
    logic [c_CA:0]           r_cmd_wp;
    logic [c_CA:0]           r_cmd_rp;

    // Response FIFO storage and pointers
    logic [READ_WIDTH-1:0]   r_rsp_mem [RSP_DEPTH];
    logic [c_RA:0]           r_rsp_wp;
    logic [c_RA:0]           r_rsp_rp;

    logic                    w_cmd_empty;
    logic                    w_cmd_full;
    logic                    w_cmd_push;
    logic                    w_cmd_pop;
    logic [CMD_WIDTH-1:0]    w_cmd_head;
    logic [c_RA:0]           w_rsp_level;
    logic                    w_rsp_empty;
    logic                    w_rsp_full;
    logic                    w_rsp_push;
    logic                    w_rsp_pop;
    logic                    w_in_xfer;
    logic                    w_rd_pending;
    logic                    w_capture;
    logic                    w_unexp;
    logic                    w_done;
    logic                    w_tmo_hit;
    logic                    w_can_issue;

    assign w_cmd_empty  = (r_cmd_wp == r_cmd_rp);
    assign w_cmd_full   = (r_cmd_wp[c_CA] != r_cmd_rp[c_CA]) &&
                          (r_cmd_wp[c_CA-1:0] == r_cmd_rp[c_CA-1:0]);
    assign w_cmd_head   = r_cmd_mem[r_cmd_rp[c_CA-1:0]];
    assign w_cmd_push   = host_cmd_vld & ~w_cmd_full;
    assign w_cmd_pop    = (r_state == S_ISSUE) & spi_cmd_rdy;

    assign w_rsp_level  = r_rsp_wp - r_rsp_rp;
    assign w_rsp_empty  = (r_rsp_wp == r_rsp_rp);
    assign w_rsp_full   = (r_rsp_wp[c_RA] != r_rsp_rp[c_RA]) &&
                          (r_rsp_wp[c_RA-1:0] == r_rsp_rp[c_RA-1:0]);
    assign w_rsp_pop    = rsp_rdy & ~w_rsp_empty;
    assign w_rsp_push   = w_capture & (~w_rsp_full | w_rsp_pop);

    // Only one read can be in flight, and it only issues when a response slot
    // is free, so the response FIFO cannot overflow.
    assign w_can_issue  = ~w_cmd_empty &
                          (w_cmd_head[RW_BIT] | (w_rsp_level < (c_RA + 1)'(RSP_DEPTH)));

    assign w_in_xfer    = (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE);
    assign w_rd_pending = w_in_xfer & r_is_read & ~r_got_rd;
    assign w_capture    = spi_read_vld & w_rd_pending;
    assign w_unexp      = spi_read_vld & ~w_rd_pending;
    assign w_done       = spi_cmd_rdy & (~r_is_read | r_got_rd | w_capture);
    assign w_tmo_hit    = (r_tmo == c_TMO_MAX);

    // Command FIFO data write (storage needs no reset)
    always_ff @(posedge clk) begin
        if (w_cmd_push) begin
            r_cmd_mem[r_cmd_wp[c_CA-1:0]] <= host_cmd;
        end
    end

    // Command FIFO pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd_wp <= '0;
            r_cmd_rp <= '0;
        end else begin
            if (w_cmd_push) r_cmd_wp <= r_cmd_wp + c_CMD_INC;
            if (w_cmd_pop)  r_cmd_rp <= r_cmd_rp + c_CMD_INC;
        end
    end

    // Response FIFO data write
    always_ff @(posedge clk) begin
        if (w_rsp_push) begin
            r_rsp_mem[r_rsp_wp[c_RA-1:0]] <= spi_read_data;
        end
    end

    // Response FIFO pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_wp <= '0;
            r_rsp_rp <= '0;
        end else begin
            if (w_rsp_push) r_rsp_wp <= r_rsp_wp + c_RSP_INC;
            if (w_rsp_pop)  r_rsp_rp <= r_rsp_rp + c_RSP_INC;
        end
    end

    // Issue/track state machine with transfer timeout counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_tmo     <= '0;
            r_is_read <= 1'b0;
            r_got_rd  <= 1'b0;
        end else begin
            if (w_capture) r_got_rd <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_can_issue) r_state <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (spi_cmd_rdy) begin
                        r_is_read <= ~w_cmd_head[RW_BIT];
                        r_got_rd  <= 1'b0;
                        r_tmo     <= '0;
                        r_state   <= S_WAIT_BUSY;
                    end
                end
                S_WAIT_BUSY: begin
                    if (w_tmo_hit) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo + c_TMO_INC;
                        if (!spi_cmd_rdy) r_state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (w_done) begin
                        r_state <= S_IDLE;
                    end else if (w_tmo_hit) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo + c_TMO_INC;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Sticky error flags; a new error in the same cycle as a clear wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_timeout <= 1'b0;
            r_err_unexp   <= 1'b0;
        end else begin
            r_err_timeout <= (w_in_xfer & w_tmo_hit & ~((r_state == S_WAIT_DONE) & w_done))
                             | (r_err_timeout & ~err_clr);
            r_err_unexp   <= w_unexp | (r_err_unexp & ~err_clr);
        end
    end

    assign host_cmd_rdy = ~w_cmd_full;
    assign cmd_level    = r_cmd_wp - r_cmd_rp;
    assign spi_cmd_vld  = (r_state == S_ISSUE);
    assign spi_cmd      = (r_state == S_ISSUE) ? w_cmd_head : '0;
    assign busy         = (r_state != S_IDLE);
    assign rsp_vld      = ~w_rsp_empty;
    assign rsp_data     = w_rsp_empty ? '0 : r_rsp_mem[r_rsp_rp[c_RA-1:0]];
    assign err_timeout  = r_err_timeout;
    assign err_unexp    = r_err_unexp;

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_cmd_sched
//  Purpose  : Directed self-checking bench for spi_cmd_sched with a
//             queue-based reference model compared every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_cmd_sched;

    localparam int c_TIMEOUT = 1024;

    logic        clk;
    logic        rst;
    logic [11:0] host_cmd;
    logic        host_cmd_vld;
    logic        host_cmd_rdy;
    logic [11:0] spi_cmd;
    logic        spi_cmd_vld;
    logic        spi_cmd_rdy;
    logic        spi_read_vld;
    logic [7:0]  spi_read_data;
    logic [7:0]  rsp_data;
    logic        rsp_vld;
    logic        rsp_rdy;
    logic [3:0]  cmd_level;
    logic        busy;
    logic        err_timeout;
    logic        err_unexp;
    logic        err_clr;

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 0;

    spi_cmd_sched dut (
        .clk           (clk),
        .rst           (rst),
        .host_cmd      (host_cmd),
        .host_cmd_vld  (host_cmd_vld),
        .host_cmd_rdy  (host_cmd_rdy),
        .spi_cmd       (spi_cmd),
        .spi_cmd_vld   (spi_cmd_vld),
        .spi_cmd_rdy   (spi_cmd_rdy),
        .spi_read_vld  (spi_read_vld),
        .spi_read_data (spi_read_data),
        .rsp_data      (rsp_data),
        .rsp_vld       (rsp_vld),
        .rsp_rdy       (rsp_rdy),
        .cmd_level     (cmd_level),
        .busy          (busy),
        .err_timeout   (err_timeout),
        .err_unexp     (err_unexp),
        .err_clr       (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [11:0] cq[$];
    logic [7:0]  rq[$];
    bit          m_offer, m_infl, m_drop, m_isrd, m_got, m_etmo, m_eunx;
    int          m_age;

    task automatic model_step();
        int          cn, rn;
        logic [11:0] hd;
        bit          rdout, cap, tset, gotnow;
        if (rst) begin
            cq.delete(); rq.delete();
            m_offer = 0; m_infl = 0; m_drop = 0; m_isrd = 0; m_got = 0;
            m_etmo = 0; m_eunx = 0; m_age = 0;
        end else begin
            cn    = cq.size();
            rn    = rq.size();
            hd    = (cn > 0) ? cq[0] : 12'h0;
            rdout = m_infl && m_isrd && !m_got;
            cap   = spi_read_vld && rdout;
            tset  = 0;
            if (m_offer) begin
                if (spi_cmd_rdy) begin
                    void'(cq.pop_front());
                    m_offer = 0; m_infl = 1; m_drop = 0; m_age = 0;
                    m_isrd = !hd[11]; m_got = 0;
                end
            end else if (m_infl) begin
                gotnow = m_got || cap;
                m_got  = gotnow;
                if (m_drop && spi_cmd_rdy && (!m_isrd || gotnow)) begin
                    m_infl = 0;
                end else if (m_age == c_TIMEOUT - 1) begin
                    m_infl = 0; tset = 1;
                end else begin
                    m_age++;
                    if (!spi_cmd_rdy) m_drop = 1;
                end
            end else if (cn > 0 && (hd[11] || rn < 4)) begin
                m_offer = 1;
            end
            if (rsp_rdy && rn > 0) void'(rq.pop_front());
            if (cap) rq.push_back(spi_read_data);
            if (host_cmd_vld && cn < 8) cq.push_back(host_cmd);
            m_etmo = tset || (m_etmo && !err_clr);
            m_eunx = (spi_read_vld && !rdout) || (m_eunx && !err_clr);
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    // Every-cycle comparison of all outputs against the model
    initial forever begin
        @(negedge clk);
        if (started) begin
            chk("cmp_host_cmd_rdy", host_cmd_rdy, cq.size() < 8);
            chk("cmp_cmd_level",    cmd_level,    cq.size());
            chk("cmp_spi_cmd_vld",  spi_cmd_vld,  m_offer);
            chk("cmp_spi_cmd",      spi_cmd,      m_offer ? cq[0] : 12'h0);
            chk("cmp_busy",         busy,         m_offer || m_infl);
            chk("cmp_rsp_vld",      rsp_vld,      rq.size() > 0);
            chk("cmp_rsp_data",     rsp_data,     (rq.size() > 0) ? rq[0] : 8'h0);
            chk("cmp_err_timeout",  err_timeout,  m_etmo);
            chk("cmp_err_unexp",    err_unexp,    m_eunx);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [11:0] c);
        host_cmd = c; host_cmd_vld = 1'b1;
        tick();
        host_cmd_vld = 1'b0;
    endtask

    // Acts as the SPI master for one transfer
    task automatic serve(input bit is_rd, input logic [7:0] d, input int nlow, input logic [11:0] exp_cmd);
        int k = 0;
        while (!spi_cmd_vld && k < 64) begin tick(); k++; end
        chk("serve_issue", spi_cmd_vld, 1);
        chk("serve_cmd", spi_cmd, exp_cmd);
        spi_cmd_rdy = 1'b1; tick();
        spi_cmd_rdy = 1'b0; repeat (nlow) tick();
        spi_cmd_rdy = 1'b1;
        if (is_rd) begin spi_read_vld = 1'b1; spi_read_data = d; end
        tick();
        spi_read_vld = 1'b0; spi_cmd_rdy = 1'b0;
    endtask

    task automatic pop(input logic [7:0] exp);
        chk("pop_vld", rsp_vld, 1);
        chk("pop_data", rsp_data, exp);
        rsp_rdy = 1'b1; tick(); rsp_rdy = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; host_cmd = '0; host_cmd_vld = 0; spi_cmd_rdy = 0;
        spi_read_vld = 0; spi_read_data = '0; rsp_rdy = 0; err_clr = 0;
        tick(); started = 1; tick();
        chk("rst_host_cmd_rdy", host_cmd_rdy, 1);
        chk("rst_spi_cmd_vld", spi_cmd_vld, 0);
        chk("rst_cmd_level", cmd_level, 0);
        rst = 1'b0; tick();

        // T1: write, N+2 issue latency, 3-cycle busy from master
        host_cmd = 12'h8A5; host_cmd_vld = 1'b1; tick(); host_cmd_vld = 1'b0;
        chk("t1_vld_n1", spi_cmd_vld, 0);
        tick();
        chk("t1_vld_n2", spi_cmd_vld, 1);
        chk("t1_cmd_n2", spi_cmd, 12'h8A5);
        serve(0, 8'h00, 3, 12'h8A5);
        chk("t1_busy", busy, 0);
        chk("t1_no_rsp", rsp_vld, 0);

        // T2: read returning 0x5A
        push(12'h3C0);
        serve(1, 8'h5A, 1, 12'h3C0);
        chk("t2_rsp_vld", rsp_vld, 1);
        chk("t2_rsp_data", rsp_data, 8'h5A);
        pop(8'h5A);
        chk("t2_rsp_empty", rsp_vld, 0);
        rsp_rdy = 1'b1; tick(); rsp_rdy = 1'b0;

        // T3: fill the command FIFO while the master is stalled
        for (int i = 0; i < 9; i++) push(12'h800 | 12'(i));
        chk("t3_level", cmd_level, 8);
        chk("t3_rdy", host_cmd_rdy, 0);
        chk("t3_head", spi_cmd, 12'h800);
        for (int i = 0; i < 8; i++) serve(0, 8'h00, 1, 12'h800 | 12'(i));
        tick(); tick();
        chk("t3_drained", cmd_level, 0);
        chk("t3_idle", busy, 0);

        // T4: five reads against a four-entry response FIFO
        for (int i = 0; i < 5; i++) push(12'h010 + 12'(i));
        for (int i = 0; i < 4; i++) serve(1, 8'hA0 + 8'(i), 1, 12'h010 + 12'(i));
        repeat (4) tick();
        chk("t4_held_busy", busy, 0);
        chk("t4_held_level", cmd_level, 1);
        chk("t4_held_vld", spi_cmd_vld, 0);
        pop(8'hA0);
        serve(1, 8'hA4, 1, 12'h014);
        pop(8'hA1); pop(8'hA2); pop(8'hA3); pop(8'hA4);
        chk("t4_empty", rsp_vld, 0);

        // T5: master never completes; timeout then next command issues
        push(12'h8F0); push(12'h8F1);
        n = 0;
        while (!spi_cmd_vld && n < 64) begin tick(); n++; end
        chk("t5_cmd", spi_cmd, 12'h8F0);
        spi_cmd_rdy = 1'b1; tick(); spi_cmd_rdy = 1'b0;
        n = 0;
        while (!err_timeout && n < 1100) begin tick(); n++; end
        chk("t5_tmo_cycles", n, c_TIMEOUT);
        serve(0, 8'h00, 1, 12'h8F1);
        chk("t5_sticky", err_timeout, 1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("t5_cleared", err_timeout, 0);

        // T6: unexpected read data during a write, then reset mid-transfer
        push(12'h8AA);
        n = 0;
        while (!spi_cmd_vld && n < 64) begin tick(); n++; end
        spi_cmd_rdy = 1'b1; tick(); spi_cmd_rdy = 1'b0; tick();
        spi_read_vld = 1'b1; spi_read_data = 8'h77; tick(); spi_read_vld = 1'b0;
        chk("t6_unexp", err_unexp, 1);
        chk("t6_no_rsp", rsp_vld, 0);
        push(12'h8BB);
        chk("t6_busy", busy, 1);
        rst = 1'b1; #1;
        chk("t6_rst_vld", spi_cmd_vld, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_level", cmd_level, 0);
        chk("t6_rst_unexp", err_unexp, 0);
        tick(); rst = 1'b0; tick();
        push(12'h801);
        serve(0, 8'h00, 1, 12'h801);
        tick(); tick();
        chk("t6_recover", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
